// File: rtl/odo_sbox_small_inv_if.sv
// Bus bundle for odo_sbox_small_inv: table-load stream, inverse lookup
// request/response and status. The master side is the host that loads the
// table and issues lookups. The slave side is the S-box inverse block.
interface odo_sbox_small_inv_if #(
    parameter int W = 6
);
    logic         load_start;
    logic         load_valid;
    logic [W-1:0] load_addr;
    logic [W-1:0] load_data;
    logic         load_end;
    logic         in_valid;
    logic [W-1:0] in;
    logic         out_valid;
    logic [W-1:0] out;
    logic         ready;
    logic         busy;
    logic         perm_error;
    logic [W:0]   miss_count;

    modport master (
        output load_start, load_valid, load_addr, load_data, load_end,
        output in_valid, in,
        input  out_valid, out, ready, busy, perm_error, miss_count
    );

    modport slave (
        input  load_start, load_valid, load_addr, load_data, load_end,
        input  in_valid, in,
        output out_valid, out, ready, busy, perm_error, miss_count
    );
endinterface

// File: rtl/odo_sbox_small_inv.sv
// odo_sbox_small_inv: inverse of the 6-bit small S-box.
// The host streams the forward table S(x) in. The block stores inv[S(x)] = x,
// scans the seen bitmap to confirm that the forward map is a permutation, and
// then serves pipelined inverse lookups.
// Optional feature: define ODO_SBOX_INV_PIPE_EN to add an extra output
// register stage, which raises the lookup latency from 1 to 2.
module odo_sbox_small_inv #(
    parameter int W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    odo_sbox_small_inv_if.slave  bus
);
    localparam int DEPTH = 1 << W;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_READY = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [DEPTH-1:0] seen_r;
    logic [W-1:0]     inv_mem [DEPTH];
    logic [W-1:0]     scan_idx_r;
    logic [W:0]       miss_count_r;
    logic             ready_r;
    logic             busy_r;
    logic             perm_error_r;
    logic             out_valid_r;
    logic [W-1:0]     out_r;

    logic             scan_last_s;
    logic             miss_inc_s;
    logic [W:0]       miss_sum_s;
    logic             write_en_s;
    logic             accept_s;

    // The scan adds one unseen entry per cycle. The final sum, which includes
    // index DEPTH-1, decides whether the block goes to READY or ERROR.
    assign scan_last_s = (state_r == ST_CHECK) && (scan_idx_r == {W{1'b1}});
    assign miss_inc_s  = ~seen_r[scan_idx_r];
    assign miss_sum_s  = miss_count_r + {{W{1'b0}}, miss_inc_s};
    // A restart in the same cycle as a load_valid beat discards that beat.
    assign write_en_s  = (state_r == ST_LOAD) && bus.load_valid && !bus.load_start;
    assign accept_s    = ready_r && bus.in_valid;

    // Next-state selection: load_start from any state restarts the load.
    always_comb begin
        state_next_s = state_r;
        if (bus.load_start) begin
            state_next_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_EMPTY: state_next_s = ST_EMPTY;
                ST_LOAD: begin
                    if (bus.load_end) begin
                        state_next_s = ST_CHECK;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end
                ST_CHECK: begin
                    if (scan_last_s) begin
                        if (miss_sum_s == {(W+1){1'b0}}) begin
                            state_next_s = ST_READY;
                        end else begin
                            state_next_s = ST_ERROR;
                        end
                    end else begin
                        state_next_s = ST_CHECK;
                    end
                end
                ST_READY: state_next_s = ST_READY;
                ST_ERROR: state_next_s = ST_ERROR;
                default:  state_next_s = ST_EMPTY;
            endcase
        end
    end

    // State register, seen bitmap, scan counter, miss accumulator and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_EMPTY;
            seen_r       <= {DEPTH{1'b0}};
            scan_idx_r   <= {W{1'b0}};
            miss_count_r <= {(W+1){1'b0}};
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            perm_error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_READY);
            busy_r  <= (state_next_s == ST_LOAD) || (state_next_s == ST_CHECK);
            if (bus.load_start) begin
                seen_r       <= {DEPTH{1'b0}};
                scan_idx_r   <= {W{1'b0}};
                miss_count_r <= {(W+1){1'b0}};
                perm_error_r <= 1'b0;
            end else begin
                if (write_en_s) begin
                    seen_r[bus.load_data] <= 1'b1;
                end
                if (state_r == ST_CHECK) begin
                    scan_idx_r   <= scan_idx_r + {{(W-1){1'b0}}, 1'b1};
                    miss_count_r <= miss_sum_s;
                    if (scan_last_s) begin
                        perm_error_r <= (miss_sum_s != {(W+1){1'b0}});
                    end
                end
            end
        end
    end

    // Inverse table RAM. It is left unreset because a full reload always
    // precedes any lookup.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            inv_mem[bus.load_data] <= bus.load_addr;
        end
    end

`ifdef ODO_SBOX_INV_PIPE_EN
    logic         pipe_valid_r;
    logic [W-1:0] pipe_data_r;

    // Two-stage lookup: RAM read register, then output register. Requests
    // that are already in flight drain after ready drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_r <= 1'b0;
            pipe_data_r  <= {W{1'b0}};
            out_valid_r  <= 1'b0;
            out_r        <= {W{1'b0}};
        end else begin
            pipe_valid_r <= accept_s;
            if (accept_s) begin
                pipe_data_r <= inv_mem[bus.in];
            end
            out_valid_r <= pipe_valid_r;
            if (pipe_valid_r) begin
                out_r <= pipe_data_r;
            end
        end
    end
`else
    // Single-stage lookup: registered RAM read. out holds its value between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_r       <= {W{1'b0}};
        end else begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_r <= inv_mem[bus.in];
            end
        end
    end
`endif

    assign bus.ready      = ready_r;
    assign bus.busy       = busy_r;
    assign bus.perm_error = perm_error_r;
    assign bus.miss_count = miss_count_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out        = out_r;
endmodule
